// File: rtl/cp0_unit.sv
// Coprocessor-0 responder for the 5-stage pipeline.
// Holds Status, Cause, EPC, Count, Compare and BadVAddr, samples the
// external interrupt lines, serves mfc0 reads combinationally and raises
// flush/redirect for exceptions and eret retiring in WB.
module cp0_unit #(
  parameter logic [31:0] EX_ENTRY = 32'h0040_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic        ex,
  input  logic [4:0]  ex_code,
  input  logic        branch_delay,
  input  logic [31:0] pc,
  input  logic [31:0] bad_vaddr,
  input  logic        eret,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic [1:0]  int_ext,
  output logic [31:0] cp0_rdata,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic [31:0] epc,
  output logic        ie,
  output logic        exl,
  output logic [7:0]  int_mask,
  output logic        int_req
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [4:0] CODE_ADEL = 5'd4;
  localparam logic [4:0] CODE_ADES = 5'd5;

  // Architectural state
  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic        cause_bd;
  logic        cause_ti;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exc;
  logic [31:0] epc_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [31:0] badvaddr_q;
  logic        tick;
  logic [1:0]  ip_hw;

  // Event decode
  logic        do_ex;
  logic        do_eret;
  logic        do_we;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic [31:0] count_inc;
  logic        ti_set;
  logic [7:0]  ip;
  logic [31:0] status_word;
  logic [31:0] cause_word;
  logic        bad_addr_code;

  // Resolve ex > eret > mtc0 priority and decode the write target
  always_comb begin
    do_ex      = wb_valid & ex;
    do_eret    = wb_valid & eret & ~ex;
    do_we      = wb_valid & cp0_we & ~ex & ~eret;
    wr_count   = do_we & (cp0_addr == REG_COUNT);
    wr_compare = do_we & (cp0_addr == REG_COMPARE);
    wr_status  = do_we & (cp0_addr == REG_STATUS);
    wr_cause   = do_we & (cp0_addr == REG_CAUSE);
    wr_epc     = do_we & (cp0_addr == REG_EPC);
    bad_addr_code = (ex_code == CODE_ADEL) | (ex_code == CODE_ADES);
  end

  // Timer compare and pending-interrupt vector
  always_comb begin
    count_inc = count_q + 32'd1;
    ti_set    = tick & ~wr_count & (count_inc == compare_q);
    ip        = {cause_ti, 3'b000, ip_hw, cause_ip_sw};
  end

  // Status: exceptions set EXL, eret clears it, mtc0 writes IM/EXL/IE
  always_ff @(posedge clk) begin
    if (rst) begin
      status_im  <= 8'h00;
      status_exl <= 1'b0;
      status_ie  <= 1'b0;
    end else if (do_ex) begin
      status_exl <= 1'b1;
    end else if (do_eret) begin
      status_exl <= 1'b0;
    end else if (wr_status) begin
      status_im  <= cp0_wdata[15:8];
      status_exl <= cp0_wdata[1];
      status_ie  <= cp0_wdata[0];
    end
  end

  // Cause: exception code and BD captured on exceptions, software IP via mtc0
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_exc   <= 5'd0;
      cause_bd    <= 1'b0;
      cause_ip_sw <= 2'b00;
    end else if (do_ex) begin
      cause_exc <= ex_code;
      if (!status_exl) begin
        cause_bd <= branch_delay;
      end
    end else if (wr_cause) begin
      cause_ip_sw <= cp0_wdata[9:8];
    end
  end

  // Timer interrupt flag: a Compare write clears it even if it would set now
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_ti <= 1'b0;
    end else if (wr_compare) begin
      cause_ti <= 1'b0;
    end else if (ti_set) begin
      cause_ti <= 1'b1;
    end
  end

  // EPC: nested exceptions (EXL already set) keep the original return PC
  always_ff @(posedge clk) begin
    if (rst) begin
      epc_q <= 32'd0;
    end else if (do_ex) begin
      if (!status_exl) begin
        epc_q <= branch_delay ? (pc - 32'd4) : pc;
      end
    end else if (wr_epc) begin
      epc_q <= cp0_wdata;
    end
  end

  // BadVAddr: captured only for address-error exceptions, never written by mtc0
  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_q <= 32'd0;
    end else if (do_ex && bad_addr_code) begin
      badvaddr_q <= bad_vaddr;
    end
  end

  // Half-rate tick that paces Count; unaffected by Count writes
  always_ff @(posedge clk) begin
    if (rst) begin
      tick <= 1'b0;
    end else begin
      tick <= ~tick;
    end
  end

  // Count: an mtc0 write takes precedence over the tick increment
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 32'd0;
    end else if (wr_count) begin
      count_q <= cp0_wdata;
    end else if (tick) begin
      count_q <= count_inc;
    end
  end

  // Compare register
  always_ff @(posedge clk) begin
    if (rst) begin
      compare_q <= 32'd0;
    end else if (wr_compare) begin
      compare_q <= cp0_wdata;
    end
  end

  // External interrupt lines are level-sampled each cycle, not latched
  always_ff @(posedge clk) begin
    if (rst) begin
      ip_hw <= 2'b00;
    end else begin
      ip_hw <= int_ext;
    end
  end

  // mfc0 read mux; unimplemented bits and addresses read zero
  always_comb begin
    status_word = {16'h0000, status_im, 6'b000000, status_exl, status_ie};
    cause_word  = {cause_bd, cause_ti, 14'h0000, ip, 1'b0, cause_exc, 2'b00};
    case (cp0_addr)
      REG_BADVADDR: cp0_rdata = badvaddr_q;
      REG_COUNT:    cp0_rdata = count_q;
      REG_COMPARE:  cp0_rdata = compare_q;
      REG_STATUS:   cp0_rdata = status_word;
      REG_CAUSE:    cp0_rdata = cause_word;
      REG_EPC:      cp0_rdata = epc_q;
      default:      cp0_rdata = 32'd0;
    endcase
  end

  // Pipeline-facing outputs; flush_pc uses the EPC value before any update
  always_comb begin
    flush    = ~rst & wb_valid & (ex | eret);
    flush_pc = ex ? EX_ENTRY : epc_q;
    epc      = epc_q;
    ie       = status_ie;
    exl      = status_exl;
    int_mask = status_im;
    int_req  = status_ie & ~status_exl & (|(ip & status_im));
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit.
module tb_cp0_unit;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic        ex;
  logic [4:0]  ex_code;
  logic        branch_delay;
  logic [31:0] pc;
  logic [31:0] bad_vaddr;
  logic        eret;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [1:0]  int_ext;
  logic [31:0] cp0_rdata;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] epc;
  logic        ie;
  logic        exl;
  logic [7:0]  int_mask;
  logic        int_req;

  int checks;
  int failures;

  cp0_unit #(.EX_ENTRY(32'h0040_0004)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .ex(ex), .ex_code(ex_code),
    .branch_delay(branch_delay), .pc(pc), .bad_vaddr(bad_vaddr), .eret(eret),
    .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .int_ext(int_ext),
    .cp0_rdata(cp0_rdata), .flush(flush), .flush_pc(flush_pc), .epc(epc),
    .ie(ie), .exl(exl), .int_mask(int_mask), .int_req(int_req)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid     = 1'b0;
    ex           = 1'b0;
    eret         = 1'b0;
    cp0_we       = 1'b0;
    branch_delay = 1'b0;
    ex_code      = 5'd0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    wb_valid  = 1'b1;
    cp0_we    = 1'b1;
    cp0_addr  = a;
    cp0_wdata = d;
    cycle();
    idle();
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cp0_addr = a;
    #1;
    d = cp0_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [4:0]  addrs [7];
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      rd(addrs[i], d);
      checks++;
      if (d !== 32'd0) begin
        failures++;
        $display("[TB] FAIL reset_read addr=%0d got=%h exp=%h", addrs[i], d, 32'd0);
      end
    end
    checks++;
    if ({flush, int_req, ie, exl, int_mask, epc, flush_pc} !== 76'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got flush=%b int_req=%b ie=%b exl=%b im=%h epc=%h fpc=%h exp all 0",
               flush, int_req, ie, exl, int_mask, epc, flush_pc);
    end
  endtask

  task automatic test_write_masks();
    logic [31:0] d;
    do_reset();
    wb_valid  = 1'b1;
    cp0_we    = 1'b1;
    cp0_addr  = 5'd12;
    cp0_wdata = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (cp0_rdata !== 32'd0) begin
      failures++;
      $display("[TB] FAIL no_bypass got=%h exp=%h", cp0_rdata, 32'd0);
    end
    cycle();
    idle();
    rd(5'd12, d);
    checks++;
    if (d !== 32'h0000_FF03) begin
      failures++;
      $display("[TB] FAIL status_mask got=%h exp=%h", d, 32'h0000_FF03);
    end
    checks++;
    if ({ie, exl, int_mask} !== 10'b11_1111_1111) begin
      failures++;
      $display("[TB] FAIL status_outputs got ie=%b exl=%b im=%h exp ie=1 exl=1 im=ff", ie, exl, int_mask);
    end
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, d);
    checks++;
    if (d !== 32'h0000_0300) begin
      failures++;
      $display("[TB] FAIL cause_mask got=%h exp=%h", d, 32'h0000_0300);
    end
    checks++;
    if (int_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL int_req_exl_block got=%b exp=0", int_req);
    end
    mtc0(5'd8, 32'hAAAA_5555);
    mtc0(5'd0, 32'h1234_5678);
    rd(5'd8, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("[TB] FAIL badvaddr_readonly got=%h exp=%h", d, 32'd0);
    end
    rd(5'd0, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("[TB] FAIL unmapped_read got=%h exp=%h", d, 32'd0);
    end
  endtask

  task automatic test_exception();
    logic [31:0] d;
    do_reset();
    wb_valid     = 1'b1;
    ex           = 1'b1;
    ex_code      = 5'd12;
    branch_delay = 1'b1;
    pc           = 32'h0040_0100;
    #1;
    checks++;
    if (flush !== 1'b1 || flush_pc !== 32'h0040_0004) begin
      failures++;
      $display("[TB] FAIL ex_flush got flush=%b pc=%h exp flush=1 pc=%h", flush, flush_pc, 32'h0040_0004);
    end
    cycle();
    idle();
    checks++;
    if (epc !== 32'h0040_00FC || exl !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ex_epc got epc=%h exl=%b exp epc=%h exl=1", epc, exl, 32'h0040_00FC);
    end
    rd(5'd13, d);
    checks++;
    if (d !== 32'h8000_0030) begin
      failures++;
      $display("[TB] FAIL ex_cause got=%h exp=%h", d, 32'h8000_0030);
    end
    wb_valid  = 1'b1;
    ex        = 1'b1;
    ex_code   = 5'd4;
    pc        = 32'h0040_0200;
    bad_vaddr = 32'h1234_5678;
    cycle();
    idle();
    checks++;
    if (epc !== 32'h0040_00FC) begin
      failures++;
      $display("[TB] FAIL nested_epc got=%h exp=%h", epc, 32'h0040_00FC);
    end
    rd(5'd13, d);
    checks++;
    if (d !== 32'h8000_0010) begin
      failures++;
      $display("[TB] FAIL nested_cause got=%h exp=%h", d, 32'h8000_0010);
    end
    rd(5'd8, d);
    checks++;
    if (d !== 32'h1234_5678) begin
      failures++;
      $display("[TB] FAIL badvaddr_capture got=%h exp=%h", d, 32'h1234_5678);
    end
  endtask

  task automatic test_eret();
    mtc0(5'd14, 32'h0040_0120);
    wb_valid  = 1'b1;
    eret      = 1'b1;
    cp0_we    = 1'b1;
    cp0_addr  = 5'd14;
    cp0_wdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (flush !== 1'b1 || flush_pc !== 32'h0040_0120) begin
      failures++;
      $display("[TB] FAIL eret_flush got flush=%b pc=%h exp flush=1 pc=%h", flush, flush_pc, 32'h0040_0120);
    end
    cycle();
    idle();
    checks++;
    if (epc !== 32'h0040_0120 || exl !== 1'b0) begin
      failures++;
      $display("[TB] FAIL eret_state got epc=%h exl=%b exp epc=%h exl=0", epc, exl, 32'h0040_0120);
    end
  endtask

  task automatic test_timer();
    logic [31:0] d;
    logic [31:0] prev;
    logic        seen;
    do_reset();
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd9, 32'd100);
    mtc0(5'd11, 32'd8);
    // Find the tick phase: Count changes right after a tick=1 edge
    rd(5'd9, prev);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      cycle();
      if (cp0_rdata !== prev) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL count_running got=%h exp=changing", cp0_rdata);
    end
    cycle();
    mtc0(5'd9, 32'd5);
    cp0_addr = 5'd13;
    for (int i = 0; i < 5; i++) cycle();
    rd(5'd13, d);
    checks++;
    if (d !== 32'd0 || int_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ti_early got cause=%h int_req=%b exp cause=0 int_req=0", d, int_req);
    end
    cycle();
    rd(5'd13, d);
    checks++;
    if (d !== 32'h4000_8000 || int_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ti_set got cause=%h int_req=%b exp cause=%h int_req=1", d, int_req, 32'h4000_8000);
    end
    rd(5'd9, d);
    checks++;
    if (d !== 32'd8) begin
      failures++;
      $display("[TB] FAIL count_value got=%h exp=%h", d, 32'd8);
    end
    mtc0(5'd11, 32'd200);
    rd(5'd13, d);
    checks++;
    if (d !== 32'd0 || int_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ti_clear got cause=%h int_req=%b exp cause=0 int_req=0", d, int_req);
    end
  endtask

  task automatic test_hw_interrupt();
    logic [31:0] d;
    do_reset();
    mtc0(5'd12, 32'h0000_0C01);
    int_ext = 2'b01;
    #1;
    checks++;
    if (int_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL int_latency got=%b exp=0", int_req);
    end
    cycle();
    checks++;
    if (int_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL int_rise got=%b exp=1", int_req);
    end
    wb_valid = 1'b1;
    ex       = 1'b1;
    ex_code  = 5'd0;
    pc       = 32'h0040_0300;
    cycle();
    idle();
    checks++;
    if (int_req !== 1'b0 || exl !== 1'b1) begin
      failures++;
      $display("[TB] FAIL int_fall got int_req=%b exl=%b exp int_req=0 exl=1", int_req, exl);
    end
    rd(5'd13, d);
    checks++;
    if (d !== 32'h0000_0400 || epc !== 32'h0040_0300) begin
      failures++;
      $display("[TB] FAIL int_cause got cause=%h epc=%h exp cause=%h epc=%h", d, epc, 32'h0000_0400, 32'h0040_0300);
    end
    wb_valid     = 1'b0;
    ex           = 1'b1;
    ex_code      = 5'd12;
    branch_delay = 1'b1;
    pc           = 32'h0040_0400;
    #1;
    checks++;
    if (flush !== 1'b0) begin
      failures++;
      $display("[TB] FAIL gated_flush got=%b exp=0", flush);
    end
    cycle();
    idle();
    rd(5'd13, d);
    checks++;
    if (d !== 32'h0000_0400 || epc !== 32'h0040_0300) begin
      failures++;
      $display("[TB] FAIL gated_state got cause=%h epc=%h exp cause=%h epc=%h", d, epc, 32'h0000_0400, 32'h0040_0300);
    end
    int_ext = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    do_reset();
    wb_valid  = 1'b1;
    ex        = 1'b1;
    ex_code   = 5'd8;
    pc        = 32'h0040_0500;
    cp0_we    = 1'b1;
    cp0_addr  = 5'd14;
    cp0_wdata = 32'h1111_1111;
    cycle();
    idle();
    checks++;
    if (epc !== 32'h0040_0500) begin
      failures++;
      $display("[TB] FAIL ex_over_mtc0 got=%h exp=%h", epc, 32'h0040_0500);
    end
    rd(5'd13, d);
    checks++;
    if (d !== 32'h0000_0020) begin
      failures++;
      $display("[TB] FAIL syscall_cause got=%h exp=%h", d, 32'h0000_0020);
    end
    mtc0(5'd14, 32'hCAFE_0000);
    mtc0(5'd11, 32'h0000_1234);
    rd(5'd14, d);
    checks++;
    if (d !== 32'hCAFE_0000) begin
      failures++;
      $display("[TB] FAIL b2b_epc got=%h exp=%h", d, 32'hCAFE_0000);
    end
    rd(5'd11, d);
    checks++;
    if (d !== 32'h0000_1234) begin
      failures++;
      $display("[TB] FAIL b2b_compare got=%h exp=%h", d, 32'h0000_1234);
    end
    rst      = 1'b1;
    wb_valid = 1'b1;
    ex       = 1'b1;
    ex_code  = 5'd10;
    pc       = 32'h0040_0600;
    #1;
    checks++;
    if (flush !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_flush got=%b exp=0", flush);
    end
    cycle();
    rst = 1'b0;
    idle();
    rd(5'd13, d);
    checks++;
    if (d !== 32'd0 || epc !== 32'd0 || exl !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_midop got cause=%h epc=%h exl=%b exp all 0", d, epc, exl);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    cp0_addr  = 5'd0;
    cp0_wdata = 32'd0;
    pc        = 32'd0;
    bad_vaddr = 32'd0;
    int_ext   = 2'b00;
    idle();
    test_reset();
    test_write_masks();
    test_exception();
    test_eret();
    test_timer();
    test_hw_interrupt();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 responder for the 5-stage pipeline.
- pipe_wb is the initiator: it presents mtc0 writes, exceptions and eret from the retiring WB instruction.
- cp0_unit holds Status, Cause, EPC, Count, Compare and BadVAddr, and samples external interrupt lines. It returns mfc0 read data, flush/redirect to IF, and the interrupt request that ID uses to tag the next instruction.

Parameters:
- EX_ENTRY, 32'h0040_0004, exception handler entry PC.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- wb_valid  in  1  WB stage holds a valid retiring instruction
- ex  in  1  retiring instruction raised an exception
- ex_code  in  5  exception code (0=Int, 4=AdEL, 5=AdES, 8=Sys, 9=Bp, 10=RI, 12=Ov)
- branch_delay  in  1  retiring instruction sits in a branch delay slot
- pc  in  32  PC of retiring instruction
- bad_vaddr  in  32  faulting address (used for codes 4/5)
- eret  in  1  retiring instruction is eret
- cp0_we  in  1  mtc0 write enable
- cp0_addr  in  5  CP0 register number (read and write)
- cp0_wdata  in  32  mtc0 data
- int_ext  in  2  external interrupt lines, level-sensitive
- cp0_rdata  out  32  mfc0 read data
- flush  out  1  flush all stages and redirect IF
- flush_pc  out  32  redirect target
- epc  out  32  current EPC
- ie  out  1  Status.IE
- exl  out  1  Status.EXL
- int_mask  out  8  Status.IM
- int_req  out  1  interrupt pending and enabled

Behaviour:
- Register map:
  - 8 = BadVAddr (read-only).
  - 9 = Count.
  - 11 = Compare.
  - 12 = Status: IM[15:8], EXL[1], IE[0]; all other bits read 0.
  - 13 = Cause: BD[31], TI[30], IP[15:8], ExcCode[6:2]; all other bits read 0.
  - 14 = EPC.
  - Any other address reads 0; writes to it are ignored.
- Reset: every register is 0, tick flop is 0, ip_hw flops are 0.
  - Output reset values: flush=0, flush_pc=EPC=0, cp0_rdata=0 for any addr, ie=exl=0, int_mask=0, int_req=0.
- Reads: cp0_rdata is combinational from cp0_addr and current register values. No read-during-write bypass; the new value is visible the next cycle.
- Write masks:
  - Status: only IM, EXL and IE are writable.
  - Cause: only IP[1:0] (bits 9:8) is writable.
  - EPC, Count and Compare are fully writable.
  - BadVAddr is not writable.
- Gating: every event below requires wb_valid=1. When wb_valid=0, ex, eret and cp0_we are ignored.
- Event priority in one cycle: ex > eret > cp0_we. A lower-priority event in the same cycle is dropped entirely.
- Exception (ex=1), register updates at the next edge:
  - ExcCode <= ex_code.
  - If EXL was 0: EPC <= branch_delay ? pc-4 : pc, and BD <= branch_delay.
  - If EXL was already 1: EPC and BD are unchanged.
  - EXL <= 1.
  - If ex_code is 4 or 5: BadVAddr <= bad_vaddr.
- eret: EXL <= 0 at the next edge.
- flush: combinational, = wb_valid & (ex|eret).
- flush_pc: ex ? EX_ENTRY : EPC, where EPC is the pre-update register value.
- Count:
  - tick toggles every cycle.
  - Count increments by 1 (mod 2^32) on cycles where tick=1. It advances once per 2 clocks.
  - An mtc0 write to Count wins over an increment in the same cycle. tick is unaffected by the write.
- Timer interrupt:
  - TI <= 1 on a cycle where tick=1, no Count write occurs, and Count+1 == Compare.
  - An mtc0 write to Compare clears TI. If the set condition and the Compare write fall in the same cycle, the clear wins.
  - TI is sticky otherwise.
- Hardware interrupt pending bits:
  - IP[7] = TI.
  - ip_hw[1:0] flops sample int_ext every cycle; IP[3:2] = ip_hw (one-cycle latency, level, not latched).
  - IP[6:4] read 0.
- int_req: combinational, = IE & ~EXL & |(IP & IM).
  - Deasserts in the cycle after EXL is set.
  - ID tags the next instruction with ex_code 0. cp0_unit does not itself take the interrupt.
- Reset mid-operation: rst overrides all events in that cycle. While rst=1, flush is forced to 0.

Test Plan:
- Reset, then read each address 8, 9, 11, 12, 13, 14, 0 -> cp0_rdata=0; flush=0; int_req=0.
- mtc0 Status=0xFFFF_FFFF, then read 12 -> 0x0000_FF03. mtc0 Cause=0xFFFF_FFFF, then read 13 -> 0x0000_0300.
- pc=0x0040_0100, branch_delay=1, ex=1, ex_code=12, EXL=0:
  - Same cycle: flush=1, flush_pc=0x0040_0004.
  - Next cycle: EPC=0x0040_00FC; Cause reads 0x8000_0030; exl=1.
  - A second ex with pc=0x0040_0200 leaves EPC=0x0040_00FC.
- With EPC=0x0040_0120 and EXL=1, eret=1 and cp0_we=1 (addr 14) in the same cycle -> flush_pc=0x0040_0120; EPC unchanged; EXL=0 next cycle.
- Write Count=5 and Compare=8 -> TI sets 6 clocks after the Count write (when Count 7->8); int_req=1 with IE=1, IM[7]=1. Writing Compare clears TI and int_req.
- IE=1, IM=0x0C, int_ext=2'b01 -> int_req rises 1 cycle later. ex with code 0 -> int_req falls next cycle. wb_valid=0 with ex=1 -> no flush, no register change.
